// File: rtl/board_pkg.sv
// Board-level constants shared by the switch conditioning path and the parity generator,
// plus the per-bit debounce state type.
package board_pkg;

    localparam int unsigned CLK_FREQ_HZ     = 100_000_000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned NUM_SW          = 8;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side signal bundle for switch_debouncer; master is the debouncer, slave its consumer.
// Optional SWITCH_DEBOUNCER_EVENT_CNT_EN adds the 16-bit event_cnt_o counter output.
interface switch_debouncer_if #(
    parameter int unsigned WIDTH = board_pkg::NUM_SW
) ();

    logic [WIDTH-1:0] sw_raw_i;
    logic [WIDTH-1:0] sw_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             changed_o;

`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
    logic [15:0]      event_cnt_o;

    modport master (
        input  sw_raw_i,
        output sw_o, rise_o, fall_o, changed_o, event_cnt_o
    );
    modport slave (
        output sw_raw_i,
        input  sw_o, rise_o, fall_o, changed_o, event_cnt_o
    );
`else
    modport master (
        input  sw_raw_i,
        output sw_o, rise_o, fall_o, changed_o
    );
    modport slave (
        output sw_raw_i,
        input  sw_o, rise_o, fall_o, changed_o
    );
`endif

endinterface

// File: rtl/debounce_bit.sv
// Single-bit debouncer: commits a new level only after CYCLES consecutive differing samples,
// emitting a registered one-cycle rise or fall pulse on the commit edge.
module debounce_bit
    import board_pkg::*;
#(
    parameter int unsigned CYCLES    = board_pkg::DEBOUNCE_CYCLES,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic sw_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W    = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    db_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sw_reg, sw_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DB_STABLE;
            cnt_reg   <= '0;
            sw_reg    <= RESET_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sw_reg    <= sw_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sw_next    = sw_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            DB_STABLE: begin
                cnt_next = '0;
                if (sync_in != sw_reg) begin
                    state_next = DB_COUNTING;
                    cnt_next   = CNT_W'(1);
                end
            end
            DB_COUNTING: begin
                if (sync_in == sw_reg) begin
                    // Bounced back to the committed level: abandon this attempt silently.
                    state_next = DB_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = DB_STABLE;
                    cnt_next   = '0;
                    sw_next    = sync_in;
                    rise_next  = sync_in;
                    fall_next  = ~sync_in;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
        endcase
    end

    assign sw_out = sw_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-flop synchroniser feeding one debounce_bit per switch.
// Optional SWITCH_DEBOUNCER_EVENT_CNT_EN adds a saturating count of changed_o pulses.
module switch_debouncer #(
    parameter int unsigned      WIDTH           = board_pkg::NUM_SW,
    parameter int unsigned      DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    switch_debouncer_if.master bus
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] sw_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_reg <= RESET_VAL;
            s2_reg <= RESET_VAL;
        end else begin
            s1_reg <= bus.sw_raw_i;
            s2_reg <= s1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .CYCLES    (DEBOUNCE_CYCLES),
                .RESET_VAL (RESET_VAL[gi])
            ) u_bit (
                .clk     (clk_i),
                .rst_n   (rst_n_i),
                .sync_in (s2_reg[gi]),
                .sw_out  (sw_vec[gi]),
                .rise    (rise_vec[gi]),
                .fall    (fall_vec[gi])
            );
        end
    endgenerate

    assign bus.sw_o      = sw_vec;
    assign bus.rise_o    = rise_vec;
    assign bus.fall_o    = fall_vec;
    // Pulses are registered per bit, so this OR lands in the same cycle as sw_o.
    assign bus.changed_o = |(rise_vec | fall_vec);

`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
    logic [15:0] event_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            event_cnt_reg <= '0;
        end else if (bus.changed_o && (event_cnt_reg != 16'hFFFF)) begin
            event_cnt_reg <= event_cnt_reg + 16'd1;
        end
    end

    assign bus.event_cnt_o = event_cnt_reg;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (DEBOUNCE_CYCLES=4): directed scenarios plus random holds, all
// checked each cycle against a sliding-window model of the debounce rule.
module tb_switch_debouncer;

    localparam int              W  = 8;
    localparam int              DC = 4;
    localparam logic [W-1:0]    RV = 8'h00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(W)) sw_if ();

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VAL       (RV)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (sw_if.master)
    );

    int checks = 0;
    int errors = 0;

    // Model: raw values still travelling through the synchroniser, and the last DC samples
    // seen after it. A bit commits when every sample in a full window differs from it.
    logic [W-1:0] pipe_q[$];
    logic [W-1:0] win_q[$];
    logic [W-1:0] exp_sw, exp_rise, exp_fall;
    logic         exp_changed;
    int           exp_evt;

    task automatic model_reset();
        pipe_q      = '{RV, RV};
        win_q.delete();
        exp_sw      = RV;
        exp_rise    = '0;
        exp_fall    = '0;
        exp_changed = 1'b0;
        exp_evt     = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] sample;
        logic         all_diff;
        if (exp_changed && exp_evt < 65535) exp_evt++;
        sample = pipe_q.pop_front();
        pipe_q.push_back(raw);
        win_q.push_back(sample);
        if (win_q.size() > DC) void'(win_q.pop_front());
        exp_rise = '0;
        exp_fall = '0;
        if (win_q.size() == DC) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (win_q[j]) if (win_q[j][i] == exp_sw[i]) all_diff = 1'b0;
                if (all_diff) begin
                    exp_rise[i] = ~exp_sw[i];
                    exp_fall[i] = exp_sw[i];
                end
            end
        end
        exp_sw      = exp_sw ^ (exp_rise | exp_fall);
        exp_changed = |(exp_rise | exp_fall);
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (sw_if.sw_o === exp_sw) else begin
            errors++; $error("FAIL %s sw_o: got %h expected %h", tag, sw_if.sw_o, exp_sw);
        end
        checks++;
        assert (sw_if.rise_o === exp_rise) else begin
            errors++; $error("FAIL %s rise_o: got %h expected %h", tag, sw_if.rise_o, exp_rise);
        end
        checks++;
        assert (sw_if.fall_o === exp_fall) else begin
            errors++; $error("FAIL %s fall_o: got %h expected %h", tag, sw_if.fall_o, exp_fall);
        end
        checks++;
        assert (sw_if.changed_o === exp_changed) else begin
            errors++; $error("FAIL %s changed_o: got %b expected %b", tag, sw_if.changed_o, exp_changed);
        end
`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
        checks++;
        assert (sw_if.event_cnt_o === 16'(exp_evt)) else begin
            errors++; $error("FAIL %s event_cnt_o: got %0d expected %0d", tag, sw_if.event_cnt_o, exp_evt);
        end
`endif
    endtask

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++; $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Hold raw for n edges; outputs are sampled 1 time unit after each rising edge.
    task automatic run(input logic [W-1:0] raw, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            sw_if.sw_raw_i = raw;
            @(posedge clk);
            if (rst_n) model_edge(raw);
            #1;
            check_outputs(tag);
        end
        $display("step %-8s raw=%h cycles=%0d rst_n=%b sw_o=%h", tag, raw, n, rst_n, sw_if.sw_o);
    endtask

    initial begin
        logic [W-1:0] v, prev;
        int           hold, exp_n;

        // Reset held with all switches up
        sw_if.sw_raw_i = 8'hFF;
        rst_n = 1'b0;
        model_reset();
        run(8'hFF, 3, "reset");
        check_val("reset_sw", 16'(sw_if.sw_o), 16'h0000);
        rst_n = 1'b1;
        run(8'hFF, 5, "release");
        check_val("release_hold_sw", 16'(sw_if.sw_o), 16'h0000);
        run(8'hFF, 1, "release");
        check_val("release_sw", 16'(sw_if.sw_o), 16'h00FF);
        check_val("release_rise", 16'(sw_if.rise_o), 16'h00FF);
        check_val("release_changed", 16'(sw_if.changed_o), 16'h0001);
        run(8'hFF, 1, "release");
        check_val("release_pulse_end", 16'(sw_if.changed_o), 16'h0000);
        run(8'hFF, 3, "release");

        // Clean step 00 -> C0
        run(8'h00, 10, "to_zero");
        run(8'hC0, 5, "step");
        check_val("step_hold_sw", 16'(sw_if.sw_o), 16'h0000);
        run(8'hC0, 1, "step");
        check_val("step_sw", 16'(sw_if.sw_o), 16'h00C0);
        check_val("step_rise", 16'(sw_if.rise_o), 16'h00C0);
        check_val("step_fall", 16'(sw_if.fall_o), 16'h0000);
        run(8'hC0, 6, "step");

        // Bit0 bounce: 3 high, 1 low, then steady high
        run(8'hC1, 3, "bnc_hi");
        run(8'hC0, 1, "bnc_lo");
        run(8'hC1, 5, "bnc_fin");
        check_val("bounce_hold_sw", 16'(sw_if.sw_o), 16'h00C0);
        run(8'hC1, 1, "bnc_fin");
        check_val("bounce_sw", 16'(sw_if.sw_o), 16'h00C1);
        run(8'hC1, 5, "bnc_fin");

        // Simultaneous rise and fall C0 -> 03
        run(8'hC0, 10, "pre_mix");
        run(8'h03, 5, "mix");
        check_val("mix_hold_sw", 16'(sw_if.sw_o), 16'h00C0);
        run(8'h03, 1, "mix");
        check_val("mix_sw", 16'(sw_if.sw_o), 16'h0003);
        check_val("mix_fall", 16'(sw_if.fall_o), 16'h00C0);
        check_val("mix_rise", 16'(sw_if.rise_o), 16'h0003);
        check_val("mix_changed", 16'(sw_if.changed_o), 16'h0001);
        run(8'h03, 1, "mix");
        check_val("mix_pulse_end", 16'(sw_if.changed_o), 16'h0000);
        run(8'h03, 4, "mix");

        // Reset in the middle of a count, then a full count after release
        run(8'h00, 10, "clr");
        run(8'h55, 3, "midcnt");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("midcnt_rst_sw", 16'(sw_if.sw_o), 16'h0000);
        run(8'h55, 2, "in_rst");
        rst_n = 1'b1;
        run(8'h55, 5, "post_rst");
        check_val("post_rst_hold_sw", 16'(sw_if.sw_o), 16'h0000);
        run(8'h55, 1, "post_rst");
        check_val("post_rst_sw", 16'(sw_if.sw_o), 16'h0055);
        run(8'h55, 4, "post_rst");

        // Asynchronous reset with a committed non-reset value must clear at once
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("async_rst_sw", 16'(sw_if.sw_o), 16'h0000);
        check_val("async_rst_rise", 16'(sw_if.rise_o), 16'h0000);
        run(8'h00, 2, "in_rst");
        rst_n = 1'b1;
        run(8'h00, 3, "idle");

        // Random values with holds both shorter and longer than the debounce window
        for (int k = 0; k < 40; k++) begin
            v    = W'($urandom);
            hold = int'($urandom_range(1, 9));
            run(v, hold, "rand");
        end
        run(8'h00, 10, "settle");

`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
        // Event counter: one count per changed_o pulse
        rst_n = 1'b0;
        model_reset();
        run(8'h00, 2, "in_rst");
        rst_n = 1'b1;
        prev  = 8'h00;
        exp_n = 0;
        for (int k = 0; k < 8; k++) begin
            v = W'($urandom % 32);
            run(v, 10, "evt");
            if (v != prev) exp_n++;
            prev = v;
        end
        check_val("event_cnt", sw_if.event_cnt_o, 16'(exp_n));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the board's slide switches. It produces the clean 8-bit switch vector that feeds the parity generator's switch input.
- Each raw asynchronous switch is synchronised with two flops, then debounced by a per-bit stability counter. Registered rise/fall/change pulses are provided for downstream sequential logic.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to commit a new value. Default is 10 ms at 100 MHz; must be >= 2.
- RESET_VAL, 8'h00, value of sw_o during and after reset (WIDTH bits).

Ports:
- clk_i, input, 1, system clock.
- rst_n_i, input, 1, asynchronous active-low reset.
- sw_raw_i, input, WIDTH, raw switch pins, asynchronous to clk_i.
- sw_o, output, WIDTH, debounced switch vector (to parity_generator sw_i).
- rise_o, output, WIDTH, per-bit one-cycle pulse when sw_o[i] commits 0->1.
- fall_o, output, WIDTH, per-bit one-cycle pulse when sw_o[i] commits 1->0.
- changed_o, output, 1, one-cycle pulse, OR of rise_o|fall_o.

Behaviour:
- Reset is asynchronous and active-low; the clock is clk_i (already decided).
- While rst_n_i=0:
  - sync stages s1, s2 = RESET_VAL;
  - sw_o = RESET_VAL;
  - counters = 0;
  - rise_o = fall_o = 0 and changed_o = 0.
- Synchroniser: s1 <= sw_raw_i, then s2 <= s1 on each clk_i rising edge. No other logic reads s1.
- Per-bit FSM, independent for each bit i:
  - STABLE: cnt=0. If s2[i] != sw_o[i], go to COUNTING with cnt <= 1.
  - COUNTING, s2[i] == sw_o[i] (bounce back): go to STABLE, cnt <= 0, no pulse.
  - COUNTING, s2[i] != sw_o[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - COUNTING, s2[i] != sw_o[i] and cnt == DEBOUNCE_CYCLES-1: commit sw_o[i] <= s2[i], pulse rise_o[i] or fall_o[i] on the same edge, go to STABLE, cnt <= 0.
- Counter width is $clog2(DEBOUNCE_CYCLES). Counters never wrap, because the commit always resets them.
- Latency: for a clean input step before edge 1, sw_o changes on edge DEBOUNCE_CYCLES+2.
- rise_o, fall_o and changed_o:
  - are registered and asserted in the same cycle sw_o takes its new value;
  - are high for exactly one cycle;
  - are never asserted simultaneously for the same bit.
- Glitch shorter than DEBOUNCE_CYCLES cycles (as seen at s2): sw_o unchanged, no pulses.
- Multiple bits committing on the same edge: each gets its own pulse, and changed_o is a single cycle high.
- Input toggling again during COUNTING toward the already-committed value: counter clears (bounce-back rule above).
- Reset asserted mid-count: everything returns to its reset values immediately (asynchronously). After release, the first commit requires a full DEBOUNCE_CYCLES count.
- Reset release with raw input != RESET_VAL: treated as a normal change, committed at edge DEBOUNCE_CYCLES+2 after release.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_EVENT_CNT_EN.
- When defined:
  - adds output event_cnt_o [15:0];
  - it is a saturating count of changed_o pulses (not of individual bit events), reset to 0;
  - it holds at 16'hFFFF once saturated.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package board_pkg holds:
  - CLK_FREQ_HZ (100000000);
  - DEBOUNCE_MS (10);
  - derived DEBOUNCE_CYCLES constant;
  - NUM_SW (8), reused by parity_generator and its bench.
- Natural sub-module: debounce_bit, a single-bit FSM plus counter plus rise/fall pulse. It is instantiated WIDTH times by a generate loop.
- The top level owns the 2-flop synchroniser, changed_o, and the optional event counter.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and RESET_VAL=0.
- Reset: hold rst_n_i=0 with sw_raw_i=8'hFF -> sw_o=8'h00 and all pulses 0. Release -> sw_o=8'hFF at edge 6 after release, rise_o=8'hFF and changed_o=1 for exactly that cycle.
- Clean step: sw_raw_i 8'h00->8'hC0 before edge 1 -> sw_o=8'hC0 at edge 6, rise_o=8'hC0 for one cycle, fall_o=0.
- Bounce: bit0 high for 3 cycles, low for 1, then high steady -> no commit during the bounce. sw_o[0]=1 on the 6th edge after the final rising transition.
- Fall plus simultaneous events: 8'hC0->8'h03 -> on one edge, sw_o=8'h03, fall_o=8'hC0, rise_o=8'h03, changed_o=1 for one cycle.
- Mid-count reset: start an 8'h00->8'h55 step, assert rst_n_i=0 after 3 edges -> sw_o=8'h00 immediately. After release with 8'h55 held, sw_o=8'h55 at edge 6.
- With SWITCH_DEBOUNCER_EVENT_CNT_EN: apply 8 random $random%32 values, each held 10 cycles -> event_cnt_o equals the number of values differing from their predecessor.
